// File: rtl/lsu_pkg.sv
// lsu_pkg: size and FSM state encodings shared by the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11} size_e;
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_e;
  function automatic logic bad_access(logic [1:0] s, logic [1:0] a);
    return s == SZ_X || (s == SZ_H && a[0]) || (s == SZ_W && a != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_format.sv
// lsu_format: load lane extract/extend and store lane merge
module lsu_format
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lane,
  input  logic [31:0] rd,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rd[8*lane +: 8];
    h = lane[1] ? rd[31:16] : rd[15:0];
    ldata = size == SZ_B ? {{24{b[7] & ~uns}}, b} : size == SZ_H ? {{16{h[15] & ~uns}}, h} : rd;
    merged = wdata;
    if (size == SZ_B) begin
      merged = rd;
      merged[8*lane +: 8] = wdata[7:0];
    end else if (size == SZ_H) begin
      merged = rd;
      merged[16*lane[1] +: 16] = wdata[15:0];
    end
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding CPU load/store to a synchronous word memory
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  state_e      state, nxt;
  logic        r_we, r_uns, r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wd, r_rdata, ldata, merged;
  lsu_format u_fmt (
    .size(r_size), .uns(r_uns), .lane(r_addr[1:0]), .rd(mem_rd), .wdata(r_wd),
    .ldata(ldata), .merged(merged)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (req_valid) nxt = bad_access(req_size, req_addr[1:0]) ? DONE : (req_we && req_size == SZ_W) ? WR : RD;
      RD: nxt = WAIT;
      WAIT: nxt = r_we ? WR : DONE;
      WR: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  // r_wd carries store data until the read-modify-write merge replaces it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      r_we <= 1'b0;
      r_uns <= 1'b0;
      r_err <= 1'b0;
      r_size <= 2'b00;
      r_addr <= '0;
      r_wd <= '0;
      r_rdata <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        r_we <= req_we;
        r_uns <= req_unsigned;
        r_size <= req_size;
        r_addr <= req_addr;
        r_wd <= req_wdata;
        r_err <= bad_access(req_size, req_addr[1:0]);
        r_rdata <= '0;
      end
      if (state == WAIT) begin
        if (r_we) r_wd <= merged;
        else r_rdata <= ldata;
      end
    end
  assign req_ready = state == IDLE;
  assign mem_a = {2'b00, r_addr[31:2]};
  assign mem_we = state == WR;
  assign mem_wd = r_wd;
  assign resp_valid = state == DONE;
  assign resp_err = resp_valid & r_err;
  assign resp_rdata = resp_valid ? r_rdata : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store vectors against a scoreboard and word-memory model
module tb_load_store_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;
  logic [31:0] mem [16] = '{0: 32'h01234567, 1: 32'h8899AABB, default: 32'h0};
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
    int          wlat;
    logic [31:0] a;
    logic [31:0] wd;
    int          acc;
  } exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0, nwe = 0, wlat = 0, busy = 0;
  logic rst_chk = 1'b0, word_chk = 1'b0, fin_chk = 1'b0;
  logic [31:0] word_exp = '0;
  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_a[3:0]] <= mem_wd;
    mem_rd <= mem[mem_a[3:0]];
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_chk) begin
      chk("rst_ready", 32'(req_ready), 1);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_resp", 32'({resp_valid, resp_err}), 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_mem_a", mem_a, 0);
      chk("rst_mem_wd", mem_wd, 0);
    end
    if (word_chk) begin
      chk("word1_after_abort", mem[1], word_exp);
      chk("ready_after_rst", 32'(req_ready), 1);
    end
    if (fin_chk) chk("queue_empty", q.size(), 0);
    busy = (!rst_n || req_ready) ? 0 : busy + 1;
    if (busy == 12) chk("hang_ready", 32'(req_ready), 1);
    if (!resp_valid) chk("idle_resp_zero", {resp_rdata[30:0], resp_err}, 0);
    if (mem_we) begin
      if (q.size() == 0) chk("stray_mem_we", 32'(mem_we), 0);
      else begin
        nwe++;
        wlat = cyc - q[0].acc;
        chk("mem_a", mem_a, q[0].a);
        chk("mem_wd", mem_wd, q[0].wd);
      end
    end
    if (resp_valid) begin
      if (q.size() == 0) chk("stray_resp", 32'(resp_valid), 0);
      else begin
        e = q.pop_front();
        chk("rdata", resp_rdata, e.rdata);
        chk("err", 32'(resp_err), 32'(e.err));
        chk("resp_cycle", 32'(cyc - e.acc), 32'(e.lat));
        chk("mem_we_count", 32'(nwe), 32'(e.nwe));
        if (e.nwe != 0) chk("mem_we_cycle", 32'(wlat), 32'(e.wlat));
        nwe = 0;
      end
    end
  end
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] er, input logic ee, input int lat,
                     input int n, input int wl, input logic [31:0] wa, input logic [31:0] ewd);
    @(negedge clk);
    #1;
    {req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata} = {1'b1, we, sz, uns, addr, wd};
    q.push_back('{er, ee, lat, n, wl, wa, ewd, cyc});
    @(posedge clk);
    #1;
    {req_valid, req_we, req_size, req_addr, req_wdata} = {1'b0, ~we, 2'b11, 32'hFFFFFFFF, 32'h0};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
  endtask
  initial begin
    rst_chk = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_chk = 1'b0;
    rst_n = 1'b1;
    txn(0, 2'b00, 0, 32'h5, 0, 32'hFFFFFFAA, 0, 3, 0, 0, 0, 0);
    txn(0, 2'b00, 1, 32'h5, 0, 32'h000000AA, 0, 3, 0, 0, 0, 0);
    txn(0, 2'b01, 0, 32'h6, 0, 32'hFFFF8899, 0, 3, 0, 0, 0, 0);
    txn(0, 2'b01, 1, 32'h6, 0, 32'h00008899, 0, 3, 0, 0, 0, 0);
    // SB aborted by reset during C2: no response, no write
    @(negedge clk);
    #1 {req_valid, req_we, req_size, req_addr, req_wdata} = {1'b1, 1'b1, 2'b00, 32'h7, 32'h11223344};
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    rst_chk = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_chk = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 word_exp = 32'h8899AABB;
    word_chk = 1'b1;
    @(negedge clk);
    #1 word_chk = 1'b0;
    txn(1, 2'b00, 0, 32'h7, 32'h11223344, 0, 0, 4, 1, 3, 1, 32'h4499AABB);
    txn(0, 2'b10, 0, 32'h4, 0, 32'h4499AABB, 0, 3, 0, 0, 0, 0);
    txn(1, 2'b10, 0, 32'h4, 32'hDEADBEEF, 0, 0, 2, 1, 1, 1, 32'hDEADBEEF);
    txn(0, 2'b10, 0, 32'h4, 0, 32'hDEADBEEF, 0, 3, 0, 0, 0, 0);
    txn(1, 2'b01, 0, 32'h2, 32'h7777BEEF, 0, 0, 4, 1, 3, 0, 32'hBEEF4567);
    txn(0, 2'b01, 1, 32'h2, 0, 32'h0000BEEF, 0, 3, 0, 0, 0, 0);
    txn(0, 2'b00, 0, 32'h3, 0, 32'hFFFFFFBE, 0, 3, 0, 0, 0, 0);
    txn(0, 2'b00, 0, 32'h0, 0, 32'h00000067, 0, 3, 0, 0, 0, 0);
    txn(0, 2'b10, 0, 32'h6, 0, 0, 1, 1, 0, 0, 0, 0);
    txn(0, 2'b11, 0, 32'h0, 0, 0, 1, 1, 0, 0, 0, 0);
    txn(1, 2'b01, 0, 32'h1, 32'h5555, 0, 1, 1, 0, 0, 0, 0);
    txn(1, 2'b10, 0, 32'h5, 32'h12345678, 0, 1, 1, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1 fin_chk = 1'b1;
    @(negedge clk);
    #1 fin_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have no parameters; widths fixed: 32-bit address and data, memory word index = addr[31:2].
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  in  1  CPU request present.
REQ-005 SHALL have port: req_ready  out  1  unit idle, request accepted when req_valid && req_ready.
REQ-006 SHALL have port: req_we  in  1  1=store, 0=load.
REQ-007 SHALL have port: req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port: req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port: req_addr  in  32  byte address.
REQ-010 SHALL have port: req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port: resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port: resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port: resp_err  out  1  qualifies resp_valid; misaligned or illegal size.
REQ-014 SHALL have ports to the word memory: mem_a out 32 (word index {2'b0, addr[31:2]}), mem_we out 1, mem_wd out 32, mem_rd in 32 (synchronous read, valid the cycle after mem_a is presented with mem_we=0).

Function
REQ-015 SHALL use an FSM with states IDLE, RD, WAIT, WR, DONE; req_ready = (state==IDLE).
REQ-016 SHALL register request fields on acceptance (cycle C0) and ignore req_* inputs until back in IDLE.
REQ-017 SHALL treat half with addr[0]=1, word with addr[1:0]!=0, or size 11 as error: IDLE->DONE, C1 resp_valid=1, resp_err=1, no memory access.
REQ-018 SHALL execute loads as IDLE->RD (C1, mem_a driven, mem_we=0)->WAIT (C2, mem_rd sampled)->DONE (C3, resp_valid=1, resp_rdata registered)->IDLE.
REQ-019 SHALL select load byte lane addr[1:0] (lane 0 = bits [7:0]) and half lane addr[1] (0 = bits [15:0]), then extend per req_unsigned.
REQ-020 SHALL execute word stores as IDLE->WR (C1, mem_we=1, mem_wd=wdata)->DONE (C2).
REQ-021 SHALL execute byte/half stores as read-modify-write: RD (C1)->WAIT (C2, merge wdata into addressed lane of mem_rd, register result)->WR (C3, mem_we=1, merged word)->DONE (C4).
REQ-022 SHALL assert mem_we only in WR, for exactly one cycle per store; mem_a stable and equal to the registered word index in RD, WAIT, WR.
REQ-023 SHALL return to IDLE from DONE unconditionally; next request accepted at the cycle after DONE, no back-to-back overlap.
REQ-024 SHALL drive resp_rdata=0 and resp_err=0 whenever resp_valid=0.

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE, mem_we=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_a=0, mem_wd=0, all request registers 0, req_ready=1.
REQ-026 SHALL abort any in-flight operation on reset assertion with no response and no memory write.

Structure
REQ-027 SHALL place the size encoding enum and FSM state enum in package lsu_pkg.
REQ-028 SHALL implement lane extract/extend and store merge in one combinational sub-module lsu_format.

Verification (memory word index 1 preloaded 0x8899AABB)
REQ-029 SHALL check LB addr 0x5 -> C3 resp_rdata=0xFFFFFFAA; LBU same -> 0x000000AA; mem_we never high.
REQ-030 SHALL check LH addr 0x6 -> 0xFFFF8899; LHU -> 0x00008899.
REQ-031 SHALL check SB addr 0x7 wdata 0x11223344 -> mem_we only in C3, mem_a=1, mem_wd=0x4499AABB; resp_valid C4, resp_err=0.
REQ-032 SHALL check SW addr 0x4 wdata 0xDEADBEEF -> mem_we in C1, resp_valid C2; subsequent LW 0x4 -> 0xDEADBEEF.
REQ-033 SHALL check LW addr 0x6 and size 11 -> C1 resp_valid=1, resp_err=1, resp_rdata=0, no mem_we.
REQ-034 SHALL check rst_n low during C2 of SB addr 0x7 -> mem_we never asserts, word unchanged 0x8899AABB, no resp_valid, req_ready=1 after release.
